// File: rtl/lab_pkg.sv
// Shared constants, glyphs and state encoding for the display path.
// Seven-segment glyphs are active-low, bit 6 = g ... bit 0 = a.
package lab_pkg;

    localparam int FX_COUNT        = 16;
    localparam int PARAM_COUNT     = 8;
    localparam int PARAM_W         = 7;
    localparam int REFRESH_CNT_MAX = 500_000;

    localparam logic [6:0] SEVSEG_SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEVSEG_SEG_ONE   = 7'h79;
    localparam logic [6:0] SEVSEG_SEG_TWO   = 7'h24;
    localparam logic [6:0] SEVSEG_SEG_THREE = 7'h30;
    localparam logic [6:0] SEVSEG_SEG_FOUR  = 7'h19;
    localparam logic [6:0] SEVSEG_SEG_FIVE  = 7'h12;
    localparam logic [6:0] SEVSEG_SEG_SIX   = 7'h02;
    localparam logic [6:0] SEVSEG_SEG_SEVEN = 7'h78;
    localparam logic [6:0] SEVSEG_SEG_EIGHT = 7'h00;
    localparam logic [6:0] SEVSEG_SEG_NINE  = 7'h10;
    localparam logic [6:0] SEVSEG_SEG_A     = 7'h08;
    localparam logic [6:0] SEVSEG_SEG_B     = 7'h03;
    localparam logic [6:0] SEVSEG_SEG_C     = 7'h46;
    localparam logic [6:0] SEVSEG_SEG_D     = 7'h21;
    localparam logic [6:0] SEVSEG_SEG_E     = 7'h06;
    localparam logic [6:0] SEVSEG_SEG_F     = 7'h0E;
    localparam logic [6:0] SEVSEG_SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEVSEG_SEG_LINE  = 7'h3F;

    localparam logic [4:0] SEVSEG_BLANK_INDEX = 5'd16;
    localparam logic [4:0] SEVSEG_LINE_INDEX  = 5'd17;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        CONVERT,
        UPDATE
    } disp_state_t;

    function automatic logic [6:0] sevseg_lookup(input logic [4:0] idx);
        case (idx)
            5'd0:               return SEVSEG_SEG_ZERO;
            5'd1:               return SEVSEG_SEG_ONE;
            5'd2:               return SEVSEG_SEG_TWO;
            5'd3:               return SEVSEG_SEG_THREE;
            5'd4:               return SEVSEG_SEG_FOUR;
            5'd5:               return SEVSEG_SEG_FIVE;
            5'd6:               return SEVSEG_SEG_SIX;
            5'd7:               return SEVSEG_SEG_SEVEN;
            5'd8:               return SEVSEG_SEG_EIGHT;
            5'd9:               return SEVSEG_SEG_NINE;
            5'd10:              return SEVSEG_SEG_A;
            5'd11:              return SEVSEG_SEG_B;
            5'd12:              return SEVSEG_SEG_C;
            5'd13:              return SEVSEG_SEG_D;
            5'd14:              return SEVSEG_SEG_E;
            5'd15:              return SEVSEG_SEG_F;
            SEVSEG_LINE_INDEX:  return SEVSEG_SEG_LINE;
            default:            return SEVSEG_SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/sevseg_encode.sv
// Combinational glyph encoder: 5-bit index to active-low segments.
module sevseg_encode
    import lab_pkg::*;
(
    input  logic [4:0] idx,
    output logic [6:0] seg
);

    assign seg = sevseg_lookup(idx);

endmodule

// File: rtl/param_display.sv
// Reads the selected effect parameter from the bank and shows it
// on six seven-segment digits as "F-P VVV" via double-dabble.
module param_display #(
    parameter int FX_COUNT        = lab_pkg::FX_COUNT,
    parameter int PARAM_COUNT     = lab_pkg::PARAM_COUNT,
    parameter int PARAM_W         = lab_pkg::PARAM_W,
    parameter int REFRESH_CNT_MAX = lab_pkg::REFRESH_CNT_MAX,
    localparam int FX_W           = $clog2(FX_COUNT),
    localparam int PS_W           = $clog2(PARAM_COUNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FX_W-1:0]    fx_sel,
    input  logic [PS_W-1:0]    param_sel,
    output logic [FX_W-1:0]    rd_fx,
    output logic [PS_W-1:0]    rd_param,
    input  logic [PARAM_W-1:0] rd_data,
    output logic               busy,
    output logic [6:0]         hex5,
    output logic [6:0]         hex4,
    output logic [6:0]         hex3,
    output logic [6:0]         hex2,
    output logic [6:0]         hex1,
    output logic [6:0]         hex0
);

    localparam int CNT_W = $clog2(REFRESH_CNT_MAX);
    localparam int BC_W  = $clog2(PARAM_W + 1);

    if (PARAM_W > 9) begin : g_width_chk
        $error("param_display: three BCD digits hold at most 9 bits");
    end

    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    lab_pkg::disp_state_t state_q, state_d;

    logic [FX_W-1:0]    rd_fx_q, rd_fx_d;
    logic [PS_W-1:0]    rd_param_q, rd_param_d;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PARAM_W-1:0] bin_q, bin_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [5:0][6:0]    hex_q, hex_d;

    logic [5:0][4:0]    idx_w;
    logic [5:0][6:0]    seg_w;
    logic               tick, sel_chg, trig;

    assign tick    = (cnt_q == CNT_W'(REFRESH_CNT_MAX - 1));
    assign sel_chg = ({fx_sel, param_sel} != {rd_fx_q, rd_param_q});
    assign trig    = tick | sel_chg | pending_q;

    // Leading zeros blank; the ones digit is always lit.
    always_comb begin
        idx_w[5] = 5'(rd_fx_q);
        idx_w[4] = lab_pkg::SEVSEG_LINE_INDEX;
        idx_w[3] = 5'(rd_param_q);
        idx_w[2] = (bcd_q[11:8] == 4'd0) ? lab_pkg::SEVSEG_BLANK_INDEX
                                         : {1'b0, bcd_q[11:8]};
        idx_w[1] = (bcd_q[11:4] == 8'd0) ? lab_pkg::SEVSEG_BLANK_INDEX
                                         : {1'b0, bcd_q[7:4]};
        idx_w[0] = {1'b0, bcd_q[3:0]};
    end

    for (genvar g = 0; g < 6; g++) begin : g_enc
        sevseg_encode u_enc (
            .idx (idx_w[g]),
            .seg (seg_w[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        rd_fx_d    = rd_fx_q;
        rd_param_d = rd_param_q;
        pending_d  = pending_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        hex_d      = hex_q;
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);

        unique case (state_q)
            lab_pkg::IDLE: begin
                if (trig) begin
                    rd_fx_d    = fx_sel;
                    rd_param_d = param_sel;
                    pending_d  = 1'b0;
                    state_d    = lab_pkg::READ;
                end
            end
            lab_pkg::READ: state_d = lab_pkg::CAPTURE;
            lab_pkg::CAPTURE: begin
                bin_d     = rd_data;
                bcd_d     = '0;
                bit_cnt_d = '0;
                state_d   = lab_pkg::CONVERT;
            end
            lab_pkg::CONVERT: begin
                {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
                bit_cnt_d      = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(PARAM_W - 1))
                    state_d = lab_pkg::UPDATE;
            end
            lab_pkg::UPDATE: begin
                hex_d   = seg_w;
                state_d = lab_pkg::IDLE;
            end
            default: state_d = lab_pkg::IDLE;
        endcase

        // Requests during a frame are remembered, never aborting it.
        if (state_q != lab_pkg::IDLE && (tick || sel_chg))
            pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= lab_pkg::IDLE;
            rd_fx_q    <= '0;
            rd_param_q <= '0;
            pending_q  <= 1'b1;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            hex_q      <= {6{lab_pkg::SEVSEG_SEG_BLANK}};
        end else begin
            state_q    <= state_d;
            rd_fx_q    <= rd_fx_d;
            rd_param_q <= rd_param_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            hex_q      <= hex_d;
        end
    end

    assign rd_fx    = rd_fx_q;
    assign rd_param = rd_param_q;
    assign busy     = (state_q != lab_pkg::IDLE);
    assign hex5     = hex_q[5];
    assign hex4     = hex_q[4];
    assign hex3     = hex_q[3];
    assign hex2     = hex_q[2];
    assign hex1     = hex_q[1];
    assign hex0     = hex_q[0];

endmodule
